// File: rtl/router_pkt_src.sv
// router_pkt_src
//   Packet source feeding the 1x3 router input port. A one-cycle request
//   (dest, len, seed) becomes a framed packet:
//     header {len, dest}, len payload bytes (seed, seed+1, ...) and an
//     even-parity byte (XOR of header and payload). Router back-pressure
//     (busy) holds the current byte. After each parity byte, GAP idle
//     cycles are inserted before the next request can be accepted.
//
//   Parameters:
//     GAP       idle cycles after each parity byte (0..15)
//   Ports:
//     clock     rising-edge clock
//     resetn    asynchronous active-low reset
//     start     request strobe, sampled only while ready=1
//     dest[1:0] destination port 0..2 (3 is rejected)
//     len[5:0]  payload length 1..63 (0 is rejected)
//     seed[7:0] first payload byte
//     busy      router back-pressure; holds the current byte
//     data_out  byte to router data_in (registered)
//     pkt_valid high for header/payload, low for parity (registered)
//     ready     high only in IDLE (decoded from the state register)
//     done      one-cycle pulse after the parity byte transfers
//     reject    one-cycle pulse after an illegal request
//     pkt_count completed packets, wraps at 16 bits
module router_pkt_src #(
  parameter int unsigned GAP = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  dest,
  input  logic [5:0]  len,
  input  logic [7:0]  seed,
  input  logic        busy,
  output logic [7:0]  data_out,
  output logic        pkt_valid,
  output logic        ready,
  output logic        done,
  output logic        reject,
  output logic [15:0] pkt_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_PARITY  = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  logic [2:0] state;
  logic [5:0] remaining;
  logic [7:0] next_byte;
  logic [7:0] parity;
  logic [3:0] gap_cnt;

  logic       req_legal;
  logic [7:0] header;

  assign req_legal = (dest != 2'd3) && (len != 6'd0);
  assign header    = {len, dest};
  assign ready     = (state == S_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      remaining <= '0;
      next_byte <= '0;
      parity    <= '0;
      gap_cnt   <= '0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      done      <= 1'b0;
      reject    <= 1'b0;
      pkt_count <= '0;
    end else begin
      done   <= 1'b0;
      reject <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (req_legal) begin
              // Header is driven straight from the request so it is on the
              // bus in the cycle after acceptance.
              state     <= S_HEADER;
              remaining <= len;
              next_byte <= seed;
              parity    <= header;
              data_out  <= header;
              pkt_valid <= 1'b1;
            end else begin
              reject <= 1'b1;
            end
          end
        end
        S_HEADER: begin
          if (!busy) begin
            state     <= S_PAYLOAD;
            data_out  <= next_byte;
            pkt_valid <= 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (!busy) begin
            parity    <= parity ^ next_byte;
            next_byte <= next_byte + 8'd1;
            remaining <= remaining - 6'd1;
            if (remaining == 6'd1) begin
              // Parity register not yet updated this edge, so fold in the
              // byte being transferred when presenting it.
              state     <= S_PARITY;
              data_out  <= parity ^ next_byte;
              pkt_valid <= 1'b0;
            end else begin
              data_out  <= next_byte + 8'd1;
              pkt_valid <= 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (!busy) begin
            done      <= 1'b1;
            pkt_count <= pkt_count + 16'd1;
            data_out  <= '0;
            pkt_valid <= 1'b0;
            gap_cnt   <= '0;
            state     <= (GAP > 0) ? S_GAP : S_IDLE;
          end
        end
        S_GAP: begin
          // Gap length is independent of busy.
          if (gap_cnt == GAP_LAST) begin
            state   <= S_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          data_out  <= '0;
          pkt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_src.sv
// tb_router_pkt_src
//   Directed bench for router_pkt_src (GAP=2). Inputs are driven and outputs
//   sampled on the falling clock edge; expected bytes are hand-computed.
module tb_router_pkt_src;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  dest;
  logic [5:0]  len;
  logic [7:0]  seed;
  logic        busy;
  logic [7:0]  data_out;
  logic        pkt_valid;
  logic        ready;
  logic        done;
  logic        reject;
  logic [15:0] pkt_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clock = ~clock;

  router_pkt_src #(.GAP(2)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .dest      (dest),
    .len       (len),
    .seed      (seed),
    .busy      (busy),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .ready     (ready),
    .done      (done),
    .reject    (reject),
    .pkt_count (pkt_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // Request for one cycle, then scramble the request inputs.
  task automatic send(input logic [1:0] d, input logic [5:0] l, input logic [7:0] s);
    start = 1'b1;
    dest  = d;
    len   = l;
    seed  = s;
    cyc();
    start = 1'b0;
    dest  = 2'($urandom);
    len   = 6'($urandom);
    seed  = 8'($urandom);
  endtask

  task automatic byte_is(input string tag, input logic [7:0] b, input logic v);
    check({tag, ".data"},  32'(data_out),  32'(b));
    check({tag, ".valid"}, 32'(pkt_valid), 32'(v));
    check({tag, ".ready"}, 32'(ready),     32'h0);
    check({tag, ".done"},  32'(done),      32'h0);
    cyc();
  endtask

  // Called on the sample right after the parity edge.
  task automatic done_is(input string tag, input logic [15:0] cnt);
    check({tag, ".done"},  32'(done),      32'h1);
    check({tag, ".count"}, 32'(pkt_count), 32'(cnt));
    check({tag, ".gdata"}, 32'(data_out),  32'h0);
    check({tag, ".gvld"},  32'(pkt_valid), 32'h0);
    check({tag, ".gap1"},  32'(ready),     32'h0);
    cyc();
    check({tag, ".dpls"},  32'(done),      32'h0);
    check({tag, ".gap2"},  32'(ready),     32'h0);
    cyc();
    check({tag, ".rdy"},   32'(ready),     32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    busy   = 1'b0;
    dest   = '0;
    len    = '0;
    seed   = '0;
    cyc();
    cyc();
    check("rst.ready", 32'(ready),     32'h1);
    check("rst.data",  32'(data_out),  32'h0);
    check("rst.valid", 32'(pkt_valid), 32'h0);
    check("rst.done",  32'(done),      32'h0);
    check("rst.rej",   32'(reject),    32'h0);
    check("rst.count", 32'(pkt_count), 32'h0);
    resetn = 1'b1;
    cyc();

    // Basic: dest0 len1 seed 0x10
    send(2'd0, 6'd1, 8'h10);
    byte_is("basic.hdr", 8'h04, 1'b1);
    byte_is("basic.p0",  8'h10, 1'b1);
    byte_is("basic.par", 8'h14, 1'b0);
    done_is("basic", 16'd1);

    // Byte wrap: dest2 len3 seed 0xFE
    send(2'd2, 6'd3, 8'hFE);
    byte_is("wrap.hdr", 8'h0E, 1'b1);
    byte_is("wrap.p0",  8'hFE, 1'b1);
    byte_is("wrap.p1",  8'hFF, 1'b1);
    byte_is("wrap.p2",  8'h00, 1'b1);
    byte_is("wrap.par", 8'h0F, 1'b0);
    done_is("wrap", 16'd2);

    // Back-pressure: dest1 len4 seed 0x20; 3 stalls on 2nd payload,
    // 1 stall on last payload, 1 stall on parity.
    send(2'd1, 6'd4, 8'h20);
    byte_is("bp.hdr", 8'h11, 1'b1);
    byte_is("bp.p0",  8'h20, 1'b1);
    busy = 1'b1;
    byte_is("bp.p1a", 8'h21, 1'b1);
    byte_is("bp.p1b", 8'h21, 1'b1);
    byte_is("bp.p1c", 8'h21, 1'b1);
    busy = 1'b0;
    byte_is("bp.p1d", 8'h21, 1'b1);
    byte_is("bp.p2",  8'h22, 1'b1);
    busy = 1'b1;
    byte_is("bp.p3a", 8'h23, 1'b1);
    busy = 1'b0;
    byte_is("bp.p3b", 8'h23, 1'b1);
    busy = 1'b1;
    byte_is("bp.para", 8'h11, 1'b0);
    busy = 1'b0;
    byte_is("bp.parb", 8'h11, 1'b0);
    done_is("bp", 16'd3);

    // Illegal requests
    send(2'd3, 6'd5, 8'h00);
    check("ill.d.rej",   32'(reject),    32'h1);
    check("ill.d.ready", 32'(ready),     32'h1);
    check("ill.d.valid", 32'(pkt_valid), 32'h0);
    cyc();
    check("ill.d.pulse", 32'(reject),    32'h0);
    send(2'd1, 6'd0, 8'h00);
    check("ill.l.rej",   32'(reject),    32'h1);
    check("ill.l.ready", 32'(ready),     32'h1);
    check("ill.l.valid", 32'(pkt_valid), 32'h0);
    cyc();
    check("ill.l.pulse", 32'(reject),    32'h0);
    check("ill.l.valid2", 32'(pkt_valid), 32'h0);
    check("ill.count",   32'(pkt_count), 32'h3);

    // Start during an active packet is ignored (both illegal and legal).
    send(2'd0, 6'd2, 8'h40);
    start = 1'b1; dest = 2'd3; len = 6'd5;
    byte_is("busy_start.hdr", 8'h08, 1'b1);
    check("busy_start.rej", 32'(reject), 32'h0);
    dest = 2'd1; len = 6'd7; seed = 8'h99;
    byte_is("busy_start.p0", 8'h40, 1'b1);
    start = 1'b0;
    byte_is("busy_start.p1", 8'h41, 1'b1);
    byte_is("busy_start.par", 8'h09, 1'b0);
    done_is("busy_start", 16'd4);

    // Reset mid-payload: dest1 len5 seed 0x30
    send(2'd1, 6'd5, 8'h30);
    byte_is("mid.hdr", 8'h15, 1'b1);
    byte_is("mid.p0",  8'h30, 1'b1);
    byte_is("mid.p1",  8'h31, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("mid.rst.data",  32'(data_out),  32'h0);
    check("mid.rst.valid", 32'(pkt_valid), 32'h0);
    check("mid.rst.ready", 32'(ready),     32'h1);
    check("mid.rst.count", 32'(pkt_count), 32'h0);
    cyc();
    cyc();
    check("mid.rst.done",  32'(done),      32'h0);
    resetn = 1'b1;
    cyc();
    check("mid.post.done", 32'(done),      32'h0);
    check("mid.post.ready", 32'(ready),    32'h1);
    send(2'd0, 6'd1, 8'h10);
    byte_is("mid2.hdr", 8'h04, 1'b1);
    byte_is("mid2.p0",  8'h10, 1'b1);
    byte_is("mid2.par", 8'h14, 1'b0);
    done_is("mid2", 16'd1);

    // Counter wrap via preload
    force dut.pkt_count = 16'hFFFF;
    cyc();
    release dut.pkt_count;
    cyc();
    check("cw.pre", 32'(pkt_count), 32'hFFFF);
    send(2'd2, 6'd1, 8'hA5);
    byte_is("cw.hdr", 8'h06, 1'b1);
    byte_is("cw.p0",  8'hA5, 1'b1);
    byte_is("cw.par", 8'hA3, 1'b0);
    done_is("cw", 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
